// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: byte stream in, key state out, for the PS/2 key tracker.
//   ps2_byte / ps2_byte_valid : scan-code byte and its one-cycle strobe
//   inputStateStorage         : held-key bitmap (29 keys)
//   key_press / key_release   : one-cycle per-key make/break pulses
//   any_key_down              : OR of the bitmap, one cycle later
// master = byte source side, slave = tracker side.
interface ps2_key_tracker_if;
    logic [7:0]  ps2_byte;
    logic        ps2_byte_valid;
    logic [28:0] inputStateStorage;
    logic [28:0] key_press;
    logic [28:0] key_release;
    logic        any_key_down;

    modport master (
        output ps2_byte,
        output ps2_byte_valid,
        input  inputStateStorage,
        input  key_press,
        input  key_release,
        input  any_key_down
    );

    modport slave (
        input  ps2_byte,
        input  ps2_byte_valid,
        output inputStateStorage,
        output key_press,
        output key_release,
        output any_key_down
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns PS/2 set-2 scan-code bytes into a held-key bitmap
// plus one-cycle press/release pulses for the 29 piano keys.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ps2_key_tracker_if.slave (byte stream in, bitmap/pulses out)
// Parameter PREFIX_TIMEOUT (>= 2): idle cycles after which a pending
// E0/F0 prefix is dropped.
// Build option KEY_TYPEMATIC_PULSE_EN: when defined, key_press also fires
// on typematic repeats of an already-held key.
module ps2_key_tracker #(
    parameter int unsigned PREFIX_TIMEOUT = 500000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_tracker_if.slave   bus
);

    localparam int unsigned NUM_KEYS = 29;
    localparam int unsigned CNT_W    = $clog2(PREFIX_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GOT_E0    = 2'd1,
        GOT_F0    = 2'd2,
        GOT_E0_F0 = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [NUM_KEYS-1:0] bitmap_q, bitmap_nxt;
    logic [NUM_KEYS-1:0] press_q, press_nxt;
    logic [NUM_KEYS-1:0] release_q, release_nxt;
    logic                any_q;
    logic [NUM_KEYS-1:0] key_hit;

    // Scan code to one-hot key position; all-zero for unmapped codes.
    function automatic logic [NUM_KEYS-1:0] decode_key(input logic [7:0] code);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        case (code)
            8'h45: k[0]  = 1'b1;
            8'h16: k[1]  = 1'b1;
            8'h1E: k[2]  = 1'b1;
            8'h26: k[3]  = 1'b1;
            8'h25: k[4]  = 1'b1;
            8'h2E: k[5]  = 1'b1;
            8'h36: k[6]  = 1'b1;
            8'h3D: k[7]  = 1'b1;
            8'h3E: k[8]  = 1'b1;
            8'h46: k[9]  = 1'b1;
            8'h0E: k[10] = 1'b1;
            8'h4E: k[11] = 1'b1;
            8'h55: k[12] = 1'b1;
            8'h66: k[13] = 1'b1;
            8'h0D: k[14] = 1'b1;
            8'h15: k[15] = 1'b1;
            8'h1D: k[16] = 1'b1;
            8'h24: k[17] = 1'b1;
            8'h2D: k[18] = 1'b1;
            8'h2C: k[19] = 1'b1;
            8'h35: k[20] = 1'b1;
            8'h3C: k[21] = 1'b1;
            8'h43: k[22] = 1'b1;
            8'h44: k[23] = 1'b1;
            8'h4D: k[24] = 1'b1;
            8'h54: k[25] = 1'b1;
            8'h5B: k[26] = 1'b1;
            8'h5D: k[27] = 1'b1;
            8'h29: k[28] = 1'b1;
            default: k = '0;
        endcase
        return k;
    endfunction

    assign key_hit = decode_key(bus.ps2_byte);

    // State, prefix-timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitmap_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            bitmap_q  <= bitmap_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            any_q     <= |bitmap_q;
        end
    end

    // Prefix decoding, bitmap update and pulse generation.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        bitmap_nxt  = bitmap_q;
        press_nxt   = '0;
        release_nxt = '0;

        if (bus.ps2_byte_valid) begin
            cnt_nxt = '0;
            case (bus.ps2_byte)
                8'hE0: begin
                    if (state_q == IDLE)        state_nxt = GOT_E0;
                    else if (state_q == GOT_F0) state_nxt = GOT_E0_F0;
                end
                8'hF0: begin
                    if (state_q == IDLE)        state_nxt = GOT_F0;
                    else if (state_q == GOT_E0) state_nxt = GOT_E0_F0;
                end
                default: begin
                    state_nxt = IDLE;
                    case (state_q)
                        IDLE: begin
`ifdef KEY_TYPEMATIC_PULSE_EN
                            press_nxt = key_hit;
`else
                            // Repeats of a held key are not new presses.
                            press_nxt = key_hit & ~bitmap_q;
`endif
                            bitmap_nxt = bitmap_q | key_hit;
                        end
                        GOT_F0: begin
                            release_nxt = key_hit & bitmap_q;
                            bitmap_nxt  = bitmap_q & ~key_hit;
                        end
                        // Extended keys are never tracked.
                        default: ;
                    endcase
                end
            endcase
        end else if (state_q != IDLE) begin
            // A stale prefix is abandoned without touching the bitmap.
            if (cnt_q == CNT_MAX) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_nxt = '0;
        end
    end

    assign bus.inputStateStorage = bitmap_q;
    assign bus.key_press         = press_q;
    assign bus.key_release       = release_q;
    assign bus.any_key_down      = any_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed checks of the PS/2 key tracker with
// PREFIX_TIMEOUT = 8. Inputs change on the falling edge; outputs are read
// on the falling edge after the rising edge that consumed a byte.
module tb_ps2_key_tracker;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.PREFIX_TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one byte for one cycle; returns one falling edge later.
    task automatic put(input logic [7:0] b);
        bus.ps2_byte       = b;
        bus.ps2_byte_valid = 1'b1;
        @(negedge clk);
        bus.ps2_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.ps2_byte_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ps2_byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL reset_bitmap got=%h want=0", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h0) begin bad++; $display("FAIL reset_press got=%h want=0", bus.key_press); end
        total++; if (bus.key_release !== 29'h0) begin bad++; $display("FAIL reset_release got=%h want=0", bus.key_release); end
        total++; if (bus.any_key_down !== 1'b0) begin bad++; $display("FAIL reset_any got=%b want=0", bus.any_key_down); end
    endtask

    task automatic test_space();
        put(8'h29);
        total++; if (bus.inputStateStorage !== 29'h1000_0000) begin bad++; $display("FAIL space_make_bitmap got=%h want=10000000", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h1000_0000) begin bad++; $display("FAIL space_press got=%h want=10000000", bus.key_press); end
        total++; if (bus.any_key_down !== 1'b0) begin bad++; $display("FAIL space_any_n1 got=%b want=0", bus.any_key_down); end
        idle(1);
        total++; if (bus.key_press !== 29'h0) begin bad++; $display("FAIL space_press_one_cycle got=%h want=0", bus.key_press); end
        total++; if (bus.any_key_down !== 1'b1) begin bad++; $display("FAIL space_any_n2 got=%b want=1", bus.any_key_down); end
        put(8'hF0);
        total++; if (bus.inputStateStorage !== 29'h1000_0000) begin bad++; $display("FAIL space_after_f0 got=%h want=10000000", bus.inputStateStorage); end
        put(8'h29);
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL space_break_bitmap got=%h want=0", bus.inputStateStorage); end
        total++; if (bus.key_release !== 29'h1000_0000) begin bad++; $display("FAIL space_release got=%h want=10000000", bus.key_release); end
        idle(1);
        total++; if (bus.key_release !== 29'h0) begin bad++; $display("FAIL space_release_one_cycle got=%h want=0", bus.key_release); end
        total++; if (bus.any_key_down !== 1'b0) begin bad++; $display("FAIL space_any_clear got=%b want=0", bus.any_key_down); end
    endtask

    // Back-to-back makes of R (index 18) then its break.
    task automatic test_back_to_back();
        int presses;
        int releases;
        int want_presses;
`ifdef KEY_TYPEMATIC_PULSE_EN
        want_presses = 3;
`else
        want_presses = 1;
`endif
        presses  = 0;
        releases = 0;
        for (int i = 0; i < 3; i++) begin
            put(8'h2D);
            presses += $countones(bus.key_press);
            releases += $countones(bus.key_release);
        end
        total++; if (bus.inputStateStorage !== 29'h0004_0000) begin bad++; $display("FAIL r_held got=%h want=00040000", bus.inputStateStorage); end
        put(8'hF0);
        presses += $countones(bus.key_press);
        releases += $countones(bus.key_release);
        put(8'h2D);
        presses += $countones(bus.key_press);
        total++; if (bus.key_release !== 29'h0004_0000) begin bad++; $display("FAIL r_release got=%h want=00040000", bus.key_release); end
        releases += $countones(bus.key_release);
        idle(1);
        presses += $countones(bus.key_press);
        releases += $countones(bus.key_release);
        total++; if (presses != want_presses) begin bad++; $display("FAIL r_press_count got=%0d want=%0d", presses, want_presses); end
        total++; if (releases != 1) begin bad++; $display("FAIL r_release_count got=%0d want=1", releases); end
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL r_final got=%h want=0", bus.inputStateStorage); end
    endtask

    task automatic test_multi_key();
        put(8'h15);
        put(8'h1D);
        total++; if (bus.inputStateStorage !== 29'h0001_8000) begin bad++; $display("FAIL qw_both got=%h want=00018000", bus.inputStateStorage); end
        put(8'hF0);
        put(8'h15);
        total++; if (bus.inputStateStorage !== 29'h0001_0000) begin bad++; $display("FAIL qw_w_only got=%h want=00010000", bus.inputStateStorage); end
        total++; if (bus.key_release !== 29'h0000_8000) begin bad++; $display("FAIL qw_q_release got=%h want=00008000", bus.key_release); end
        idle(1);
        total++; if (bus.any_key_down !== 1'b1) begin bad++; $display("FAIL qw_any got=%b want=1", bus.any_key_down); end
    endtask

    // Starts with W (index 16) held from the previous task.
    task automatic test_extended();
        put(8'hE0);
        put(8'h29);
        total++; if (bus.inputStateStorage !== 29'h0001_0000) begin bad++; $display("FAIL ext_make_bitmap got=%h want=00010000", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h0) begin bad++; $display("FAIL ext_make_press got=%h want=0", bus.key_press); end
        put(8'hE0);
        put(8'hF0);
        put(8'h1D);
        total++; if (bus.inputStateStorage !== 29'h0001_0000) begin bad++; $display("FAIL ext_break_bitmap got=%h want=00010000", bus.inputStateStorage); end
        total++; if (bus.key_release !== 29'h0) begin bad++; $display("FAIL ext_break_release got=%h want=0", bus.key_release); end
        put(8'h29);
        total++; if (bus.inputStateStorage !== 29'h1001_0000) begin bad++; $display("FAIL ext_then_space got=%h want=10010000", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h1000_0000) begin bad++; $display("FAIL ext_then_press got=%h want=10000000", bus.key_press); end
    endtask

    task automatic test_timeout();
        do_reset();
        put(8'hF0);
        idle(8);
        put(8'h45);
        total++; if (bus.inputStateStorage !== 29'h1) begin bad++; $display("FAIL to_make_bitmap got=%h want=1", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h1) begin bad++; $display("FAIL to_make_press got=%h want=1", bus.key_press); end
        put(8'hF0);
        idle(6);
        put(8'h45);
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL to_break_bitmap got=%h want=0", bus.inputStateStorage); end
        total++; if (bus.key_release !== 29'h1) begin bad++; $display("FAIL to_break_release got=%h want=1", bus.key_release); end
        put(8'h99);
        total++; if (bus.inputStateStorage !== 29'h0 || bus.key_press !== 29'h0) begin bad++; $display("FAIL unmapped got=%h/%h want=0/0", bus.inputStateStorage, bus.key_press); end
    endtask

    // Reset colliding with a strobe, after a pending F0 and a held key.
    task automatic test_reset_collide();
        put(8'h29);
        put(8'hF0);
        reset              = 1'b1;
        bus.ps2_byte       = 8'h16;
        bus.ps2_byte_valid = 1'b1;
        @(negedge clk);
        reset              = 1'b0;
        bus.ps2_byte_valid = 1'b0;
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL rc_bitmap got=%h want=0", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h0 || bus.key_release !== 29'h0) begin bad++; $display("FAIL rc_pulses got=%h/%h want=0/0", bus.key_press, bus.key_release); end
        total++; if (bus.any_key_down !== 1'b0) begin bad++; $display("FAIL rc_any got=%b want=0", bus.any_key_down); end
        idle(1);
        total++; if (bus.inputStateStorage !== 29'h0) begin bad++; $display("FAIL rc_after got=%h want=0", bus.inputStateStorage); end
        put(8'h16);
        total++; if (bus.inputStateStorage !== 29'h2) begin bad++; $display("FAIL rc_make_after got=%h want=2", bus.inputStateStorage); end
        total++; if (bus.key_press !== 29'h2) begin bad++; $display("FAIL rc_press_after got=%h want=2", bus.key_press); end
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        reset              = 1'b1;
        bus.ps2_byte       = 8'h00;
        bus.ps2_byte_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_space();
        test_back_to_back();
        test_multi_key();
        test_extended();
        test_timeout();
        test_reset_collide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
